// File: rtl/ntsc_mem_write_if.sv
// Memory write-request bus between the NTSC capture packer and the memory arbiter.
// The master raises ntsc_flag with a packed word and its coordinates. The slave
// answers each request with a one-cycle done_ntsc.
interface ntsc_mem_write_if;
  logic        ntsc_flag;
  logic [35:0] ntsc_pixel;
  logic [9:0]  ntsc_hcount;
  logic [9:0]  ntsc_vcount;
  logic        done_ntsc;

  modport master (
    output ntsc_flag, ntsc_pixel, ntsc_hcount, ntsc_vcount,
    input  done_ntsc
  );

  modport slave (
    input  ntsc_flag, ntsc_pixel, ntsc_hcount, ntsc_vcount,
    output done_ntsc
  );
endinterface

// File: rtl/ntsc_mem_write.sv
// NTSC capture writer. It packs even/odd YCrCb pixel pairs into 36-bit words and
// tags each word with its frame position. Words are queued in a small FIFO and
// issued to memory over the flag/done handshake. frame_flag pulses once the last
// word of a frame has been acknowledged.
//
// state | meaning
// IDLE  | no request outstanding; loads the FIFO head when one is available
// REQ   | ntsc_flag high; outputs hold the FIFO head until done_ntsc
module ntsc_mem_write #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int LOG_FIFO = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pix_valid,
  input  logic [17:0]             pixel_ycrcb,
  input  logic                    sol,
  input  logic                    sof,
  ntsc_mem_write_if.master        mem,
  output logic                    frame_flag,
  output logic                    overflow
);

  localparam int                DEPTH  = 1 << LOG_FIFO;
  localparam logic [9:0]        H_LIM  = 10'(H_ACTIVE);
  localparam logic [9:0]        V_LIM  = 10'(V_ACTIVE);
  localparam logic [LOG_FIFO:0] FULL   = (LOG_FIFO + 1)'(DEPTH);
  localparam logic [LOG_FIFO:0] ONE    = (LOG_FIFO + 1)'(1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t              state;
  logic [9:0]          x, y, x_eff, y_eff;
  logic                armed;
  logic [17:0]         half;
  logic                capture, push, pop, full, push_ok, drop;

  logic [35:0]         fifo_data [DEPTH];
  logic [9:0]          fifo_x    [DEPTH];
  logic [9:0]          fifo_y    [DEPTH];
  logic [LOG_FIFO-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [LOG_FIFO:0]   count;

  // Line/frame markers act before the beat they coincide with, so that beat is pixel 0.
  always_comb begin
    x_eff = x;
    y_eff = y;
    if (sof) begin
      x_eff = '0;
      y_eff = '0;
    end else if (sol) begin
      x_eff = '0;
      if (y < V_LIM) y_eff = y + 10'd1;
    end
    capture = (armed | sof) & pix_valid & (x_eff < H_LIM) & (y_eff < V_LIM);
    push    = capture & x_eff[0];
    pop     = (state == REQ) & mem.done_ntsc;
    full    = (count == FULL);
    push_ok = push & (~full | pop);
    drop    = push & full & ~pop;
    rd_nxt  = rd_ptr + LOG_FIFO'(1);
  end

  // Pixel position counters and the even-pixel holding register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x     <= '0;
      y     <= '0;
      armed <= 1'b0;
      half  <= '0;
    end else begin
      if (sof) armed <= 1'b1;
      x <= capture ? x_eff + 10'd1 : x_eff;
      y <= y_eff;
      if (capture && !x_eff[0]) half <= pixel_ycrcb;
    end
  end

  // FIFO storage; entries are only read once count says they were written.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      fifo_data[wr_ptr] <= {half, pixel_ycrcb};
      fifo_x[wr_ptr]    <= x_eff - 10'd1;
      fifo_y[wr_ptr]    <= y_eff;
    end
  end

  // FIFO pointers, occupancy and the sticky drop indicator.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + LOG_FIFO'(1);
      if (pop)     rd_ptr <= rd_nxt;
      case ({push_ok, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      if (sof)       overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

  // Write handshake: the head stays in the FIFO until it is acknowledged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      mem.ntsc_flag   <= 1'b0;
      mem.ntsc_pixel  <= '0;
      mem.ntsc_hcount <= '0;
      mem.ntsc_vcount <= '0;
      frame_flag      <= 1'b0;
    end else begin
      frame_flag <= pop && (mem.ntsc_hcount == H_LIM - 10'd2) &&
                    (mem.ntsc_vcount == V_LIM - 10'd1);
      case (state)
        IDLE: begin
          if (count != '0) begin
            mem.ntsc_pixel  <= fifo_data[rd_ptr];
            mem.ntsc_hcount <= fifo_x[rd_ptr];
            mem.ntsc_vcount <= fifo_y[rd_ptr];
            mem.ntsc_flag   <= 1'b1;
            state           <= REQ;
          end
        end
        REQ: begin
          if (mem.done_ntsc) begin
            if (count > ONE) begin
              mem.ntsc_pixel  <= fifo_data[rd_nxt];
              mem.ntsc_hcount <= fifo_x[rd_nxt];
              mem.ntsc_vcount <= fifo_y[rd_nxt];
            end else begin
              mem.ntsc_flag <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntsc_mem_write.sv
// Bench for ntsc_mem_write with a reduced frame size. A transaction-level model
// tracks pixel position, pairing, FIFO occupancy and overflow. The model is
// checked against the DUT outputs on every cycle, and directed scenarios pin it
// with hand-computed words.
module tb_ntsc_mem_write;
  localparam int H     = 16;
  localparam int V     = 4;
  localparam int LF    = 3;
  localparam int DEPTH = 1 << LF;
  localparam logic [9:0] H_LAST = 10'(H - 2);
  localparam logic [9:0] V_LAST = 10'(V - 1);

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pix_valid = 1'b0;
  logic [17:0] pixel_ycrcb = '0;
  logic        sol = 1'b0;
  logic        sof = 1'b0;
  logic        frame_flag, overflow;

  ntsc_mem_write_if mem ();

  ntsc_mem_write #(.H_ACTIVE(H), .V_ACTIVE(V), .LOG_FIFO(LF)) dut (
    .clock       (clock),
    .reset       (reset),
    .pix_valid   (pix_valid),
    .pixel_ycrcb (pixel_ycrcb),
    .sol         (sol),
    .sof         (sof),
    .mem         (mem),
    .frame_flag  (frame_flag),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  int nvec = 0;
  int nfail = 0;
  int ack_mode = 0;
  int wcnt = 0;
  int ff_count = 0;

  // expected FIFO contents (head at index 0) and log of acknowledged writes
  logic [35:0] eq_pix [$];
  logic [9:0]  eq_h   [$];
  logic [9:0]  eq_v   [$];
  logic [35:0] log_pix [$];
  logic [9:0]  log_h   [$];
  logic [9:0]  log_v   [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // memory-side responder: 0 never acks, 1 acks at once, 2 acks two cycles in, 3 random
  initial begin
    mem.done_ntsc = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        mem.done_ntsc = 1'b0;
        wcnt = 0;
      end else begin
        case (ack_mode)
          1: mem.done_ntsc = mem.ntsc_flag;
          2: begin
            if (mem.ntsc_flag) begin
              if (wcnt == 2) begin
                mem.done_ntsc = 1'b1;
                wcnt = 0;
              end else begin
                mem.done_ntsc = 1'b0;
                wcnt++;
              end
            end else begin
              mem.done_ntsc = 1'b0;
              wcnt = 0;
            end
          end
          3: mem.done_ntsc = ($urandom_range(0, 2) == 0);
          default: mem.done_ntsc = 1'b0;
        endcase
      end
    end
  end

  // behavioural model state
  int          mx, my, occ_before;
  bit          marmed, movf, pflag, pop, exp_ff, exp_flag, push_req;
  logic [17:0] mhalf;
  logic [35:0] ppix, pw;
  logic [9:0]  ph, pv, pwh, pwv;

  initial begin
    mx = 0; my = 0; marmed = 0; movf = 0; pflag = 0; mhalf = '0;
    ppix = '0; ph = '0; pv = '0;
  end

  always begin
    @(posedge clock);
    #1;
    if (reset) begin
      chk("reset_outs", 64'({mem.ntsc_flag, mem.ntsc_pixel, mem.ntsc_hcount,
                             mem.ntsc_vcount, frame_flag, overflow}), 64'd0);
      mx = 0; my = 0; marmed = 0; movf = 0; pflag = 0; mhalf = '0;
      eq_pix.delete(); eq_h.delete(); eq_v.delete();
    end else begin
      occ_before = eq_pix.size();
      pop    = pflag && mem.done_ntsc;
      exp_ff = pop && (ph == H_LAST) && (pv == V_LAST);
      if (pop) begin
        log_pix.push_back(ppix); log_h.push_back(ph); log_v.push_back(pv);
        if (eq_pix.size() > 0) begin
          void'(eq_pix.pop_front()); void'(eq_h.pop_front()); void'(eq_v.pop_front());
        end
      end
      push_req = 0;
      if (sof) begin
        mx = 0; my = 0; marmed = 1; movf = 0;
      end else if (sol) begin
        mx = 0;
        if (my < V) my++;
      end
      if (marmed && pix_valid && mx < H && my < V) begin
        if (mx % 2 == 0) mhalf = pixel_ycrcb;
        else begin
          push_req = 1;
          pw  = {mhalf, pixel_ycrcb};
          pwh = 10'(mx - 1);
          pwv = 10'(my);
        end
        mx++;
      end
      if (push_req) begin
        if (occ_before < DEPTH || pop) begin
          eq_pix.push_back(pw); eq_h.push_back(pwh); eq_v.push_back(pwv);
        end else movf = 1;
      end
      exp_flag = pop ? (occ_before > 1) : (occ_before > 0);
      chk("flag", 64'(mem.ntsc_flag), 64'(exp_flag));
      if (exp_flag && eq_pix.size() > 0)
        chk("word", 64'({mem.ntsc_pixel, mem.ntsc_hcount, mem.ntsc_vcount}),
            64'({eq_pix[0], eq_h[0], eq_v[0]}));
      chk("overflow", 64'(overflow), 64'(movf));
      chk("frame_flag", 64'(frame_flag), 64'(exp_ff));
      if (frame_flag) ff_count++;
      pflag = mem.ntsc_flag;
      ppix  = mem.ntsc_pixel;
      ph    = mem.ntsc_hcount;
      pv    = mem.ntsc_vcount;
    end
  end

  task automatic drive(input logic [17:0] p, input logic s_l, input logic s_f, input logic v);
    @(negedge clock);
    pixel_ycrcb = p;
    sol         = s_l;
    sof         = s_f;
    pix_valid   = v;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(18'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((eq_pix.size() > 0 || mem.ntsc_flag) && k < budget) begin
      @(posedge clock);
      #2;
      k++;
    end
    chk("drain_in_budget", 64'(k < budget), 64'd1);
  endtask

  int base, ffb, nl, len;
  logic [17:0] pa, pb, pc, pd, pe;

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("post_reset_flag", 64'(mem.ntsc_flag), 64'd0);
    chk("post_reset_pixel", 64'(mem.ntsc_pixel), 64'd0);
    chk("post_reset_ovf", 64'(overflow), 64'd0);

    // four beats, delayed acks
    ack_mode = 2;
    base = log_pix.size();
    drive(18'h00001, 1'b0, 1'b1, 1'b1);
    drive(18'h00002, 1'b0, 1'b0, 1'b1);
    @(posedge clock); #1;
    chk("lat_pre", 64'(mem.ntsc_flag), 64'd0);
    drive(18'h00003, 1'b0, 1'b0, 1'b1);
    @(posedge clock); #1;
    chk("lat_post", 64'(mem.ntsc_flag), 64'd1);
    chk("lat_word", 64'(mem.ntsc_pixel), 64'h0_0004_0002);
    drive(18'h00004, 1'b0, 1'b0, 1'b1);
    idle(1);
    drain(200);
    chk("t1_count", 64'(log_pix.size() - base), 64'd2);
    chk("t1_w0", 64'({log_pix[base], log_h[base], log_v[base]}),
        64'({36'h0_0004_0002, 10'd0, 10'd0}));
    chk("t1_w1", 64'({log_pix[base+1], log_h[base+1], log_v[base+1]}),
        64'({36'h0_000C_0004, 10'd2, 10'd0}));
    chk("t1_flag_off", 64'(mem.ntsc_flag), 64'd0);

    // one line of H+1 beats
    ack_mode = 1;
    base = log_pix.size();
    drive(18'($urandom), 1'b0, 1'b1, 1'b1);
    repeat (H) drive(18'($urandom), 1'b0, 1'b0, 1'b1);
    idle(2);
    drain(200);
    chk("t2_count", 64'(log_pix.size() - base), 64'(H / 2));
    chk("t2_last_x", 64'(log_h[log_h.size()-1]), 64'(H - 2));

    // half pair discarded at sol
    base = log_pix.size();
    pa = 18'h12345; pb = 18'h2abcd; pc = 18'h3f00f; pd = 18'h00111; pe = 18'h22222;
    drive(pa, 1'b0, 1'b1, 1'b1);
    drive(pb, 1'b0, 1'b0, 1'b1);
    drive(pc, 1'b0, 1'b0, 1'b1);
    drive(pd, 1'b1, 1'b0, 1'b1);
    drive(pe, 1'b0, 1'b0, 1'b1);
    idle(2);
    drain(200);
    chk("t3_count", 64'(log_pix.size() - base), 64'd2);
    chk("t3_w0", 64'({log_pix[base], log_h[base], log_v[base]}),
        64'({pa, pb, 10'd0, 10'd0}));
    chk("t3_w1", 64'({log_pix[base+1], log_h[base+1], log_v[base+1]}),
        64'({pd, pe, 10'd0, 10'd1}));

    // ten pairs with no acks: eight queued, two dropped
    ack_mode = 0;
    base = log_pix.size();
    drive(18'($urandom), 1'b0, 1'b1, 1'b1);
    repeat (11) drive(18'($urandom), 1'b0, 1'b0, 1'b1);
    drive(18'($urandom), 1'b1, 1'b0, 1'b1);
    repeat (7) drive(18'($urandom), 1'b0, 1'b0, 1'b1);
    idle(2);
    @(posedge clock); #1;
    chk("t4_ovf_set", 64'(overflow), 64'd1);
    chk("t4_flag_held", 64'(mem.ntsc_flag), 64'd1);
    ack_mode = 1;
    idle(1);
    drain(200);
    chk("t4_count", 64'(log_pix.size() - base), 64'd8);
    chk("t4_last", 64'({log_h[log_h.size()-1], log_v[log_v.size()-1]}), 64'({10'd2, 10'd1}));
    chk("t4_ovf_sticky", 64'(overflow), 64'd1);
    drive(18'd0, 1'b0, 1'b1, 1'b0);
    drive(18'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
    chk("t4_ovf_clear", 64'(overflow), 64'd0);

    // full frame with immediate acks
    base = log_pix.size();
    ffb = ff_count;
    for (int l = 0; l < V; l++)
      for (int i = 0; i < H; i++)
        drive(18'($urandom), 1'(l > 0 && i == 0), 1'(l == 0 && i == 0), 1'b1);
    idle(2);
    drain(200);
    chk("t5_count", 64'(log_pix.size() - base), 64'(H * V / 2));
    chk("t5_frame_pulses", 64'(ff_count - ffb), 64'd1);

    // asynchronous reset with three words queued
    ack_mode = 0;
    drive(18'($urandom), 1'b0, 1'b1, 1'b1);
    repeat (5) drive(18'($urandom), 1'b0, 1'b0, 1'b1);
    idle(2);
    chk("t6_flag_before", 64'(mem.ntsc_flag), 64'd1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("t6_async_flag", 64'(mem.ntsc_flag), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    ack_mode = 1;
    base = log_pix.size();
    drive(18'($urandom), 1'b1, 1'b0, 1'b1);
    repeat (5) drive(18'($urandom), 1'b0, 1'b0, 1'b1);
    idle(10);
    chk("t6_no_write", 64'(log_pix.size() - base), 64'd0);
    drive(18'($urandom), 1'b0, 1'b1, 1'b1);
    drive(18'($urandom), 1'b0, 1'b0, 1'b1);
    idle(2);
    drain(200);
    chk("t6_rearm", 64'(log_pix.size() - base), 64'd1);

    // randomized frames, line lengths, gaps and ack behaviour
    for (int f = 0; f < 10; f++) begin
      ack_mode = $urandom_range(0, 3);
      drive(18'($urandom), 1'b0, 1'b1, 1'($urandom_range(0, 1)));
      nl = $urandom_range(1, V + 2);
      for (int l = 0; l < nl; l++) begin
        if (l > 0) drive(18'($urandom), 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        len = $urandom_range(0, H + 3);
        for (int i = 0; i < len; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          drive(18'($urandom), 1'b0, 1'b0, 1'b1);
        end
      end
      idle(3);
      if (ack_mode == 0) ack_mode = 1;
      drain(2000);
    end

    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
